// File: rtl/tongbufifo_pkg.sv
// Shared helpers for the single-clock FIFO: derived widths and parameter
// legality checks evaluated at elaboration time.
package tongbufifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram_sdp
    import tongbufifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16384
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [addr_w(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [addr_w(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tongbufifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky error flags,
// synchronous flush and a registered or first-word-fall-through read port.
module tongbufifo
    import tongbufifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16384,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = 1;

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("tongbufifo: DEPTH must be a power of two and at least 4");
    end
    if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("tongbufifo: AF_THRESH or AE_THRESH out of range");
    end

    logic [ADDR_W:0]    wr_ptr, rd_ptr;
    logic [ADDR_W:0]    wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]   count_nxt;
    logic               wr_acc, rd_acc;
    logic [DATA_W-1:0]  ram_rdata;

    // Pointers wrap at 2*DEPTH, so their difference is the exact occupancy.
    assign count  = wr_ptr - rd_ptr;
    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full && !flush;
    assign rd_acc = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_ONE;
        end
        count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            almost_full  <= (count_nxt >= CNT_W'(AF_THRESH));
            almost_empty <= (count_nxt <= CNT_W'(AE_THRESH));
            if (flush) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_en && full)  overflow  <= 1'b1;
                if (rd_en && empty) underflow <= 1'b1;
            end
        end
    end

    fifo_ram_sdp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (din),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign dout = empty ? '0 : ram_rdata;
    end else begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout <= '0;
            end else if (flush) begin
                dout <= '0;
            end else if (rd_acc) begin
                dout <= ram_rdata;
            end
        end
    end

endmodule
